uart_iram_loader: RTL and testbench

- Sits between the UART receive FIFO and the microcontroller instruction-RAM write port.
- Pops received bytes, parses a framed program image, assembles 16-bit words with the high byte first, and writes them to consecutive IRAM addresses.
- Holds the CPU during a load and reports done or error status for LED and 7-segment display.

---
 rtl/uart_iram_loader_if.sv | 22 ++
 rtl/uart_iram_loader.sv | 176 +++++++++++++++++
 tb/tb_uart_iram_loader.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/uart_iram_loader_if.sv
// Byte stream from the UART receive FIFO and the instruction-RAM write port.
interface uart_iram_loader_if #(
    parameter int unsigned WIDTH          = 16,
    parameter int unsigned IRAM_ADDR_BITS = 8
);
    logic                      rx_empty;
    logic [7:0]                r_data;
    logic                      rd_uart;
    logic [IRAM_ADDR_BITS-1:0] iram_wa;
    logic                      iram_wen;
    logic [WIDTH-1:0]          iram_din;

    modport master (
        input  rx_empty, r_data,
        output rd_uart, iram_wa, iram_wen, iram_din
    );

    modport slave (
        output rx_empty, r_data,
        input  rd_uart, iram_wa, iram_wen, iram_din
    );
endinterface

// File: rtl/uart_iram_loader.sv
// Parses SYNC/count/data/checksum frames from the UART FIFO and writes
// big-endian 16-bit words to consecutive IRAM addresses, holding the CPU meanwhile.
module uart_iram_loader #(
    parameter int unsigned WIDTH          = 16,
    parameter int unsigned IRAM_ADDR_BITS = 8,
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter int unsigned TIMEOUT_CYCLES = 5000000
) (
    input  logic                clk,
    input  logic                reset,
    uart_iram_loader_if.master  bus,
    output logic                cpu_hold,
    output logic                load_done,
    output logic                load_error,
    output logic [7:0]          words_loaded
);
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE, COUNT, DATA_HI, DATA_LO, WRITE, CHECK, DONE, ERROR
    } state_t;

    state_t                    state_q, state_d;
    logic                      rd_q, rd_d;
    logic [IRAM_ADDR_BITS-1:0] addr_q, addr_d;
    logic                      wen_q, wen_d;
    logic [WIDTH-1:0]          din_q, din_d;
    logic                      hold_q, hold_d;
    logic                      done_q, done_d;
    logic                      err_q, err_d;
    logic [7:0]                wl_q, wl_d;
    logic [7:0]                n_q, n_d;
    logic [8:0]                idx_q, idx_d;
    logic [7:0]                hi_q, hi_d;
    logic [7:0]                csum_q, csum_d;
    logic [TMO_W-1:0]          tmo_q, tmo_d;

    logic       take_c;
    logic       counting_c;
    logic       timeout_c;
    logic [8:0] n_words_c;

    // A byte is taken only when none was popped last cycle, so the FIFO head has settled.
    assign take_c     = !bus.rx_empty && !rd_q && (state_q != WRITE);
    assign counting_c = (state_q == COUNT) || (state_q == DATA_HI) ||
                        (state_q == DATA_LO) || (state_q == CHECK);
    assign timeout_c  = counting_c && !take_c && (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));
    assign n_words_c  = (n_q == 8'd0) ? 9'd256 : {1'b0, n_q};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            rd_q    <= 1'b0;
            addr_q  <= '0;
            wen_q   <= 1'b0;
            din_q   <= '0;
            hold_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            wl_q    <= '0;
            n_q     <= '0;
            idx_q   <= '0;
            hi_q    <= '0;
            csum_q  <= '0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            rd_q    <= rd_d;
            addr_q  <= addr_d;
            wen_q   <= wen_d;
            din_q   <= din_d;
            hold_q  <= hold_d;
            done_q  <= done_d;
            err_q   <= err_d;
            wl_q    <= wl_d;
            n_q     <= n_d;
            idx_q   <= idx_d;
            hi_q    <= hi_d;
            csum_q  <= csum_d;
            tmo_q   <= tmo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rd_d    = take_c;
        addr_d  = addr_q;
        wen_d   = 1'b0;
        din_d   = din_q;
        hold_d  = hold_q;
        done_d  = done_q;
        err_d   = err_q;
        wl_d    = wl_q;
        n_d     = n_q;
        idx_d   = idx_q;
        hi_d    = hi_q;
        csum_d  = csum_q;
        tmo_d   = tmo_q;

        if (take_c)
            tmo_d = '0;
        else if (counting_c)
            tmo_d = tmo_q + TMO_W'(1);

        case (state_q)
            IDLE, DONE, ERROR: begin
                if (take_c && (bus.r_data == SYNC_BYTE)) begin
                    state_d = COUNT;
                    hold_d  = 1'b1;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    wl_d    = '0;
                    addr_d  = '0;
                    idx_d   = '0;
                    csum_d  = '0;
                end
            end
            COUNT: begin
                if (take_c) begin
                    n_d     = bus.r_data;
                    state_d = DATA_HI;
                end
            end
            DATA_HI: begin
                if (take_c) begin
                    hi_d    = bus.r_data;
                    csum_d  = csum_q + bus.r_data;
                    state_d = DATA_LO;
                end
            end
            DATA_LO: begin
                if (take_c) begin
                    din_d   = WIDTH'({hi_q, bus.r_data});
                    csum_d  = csum_q + bus.r_data;
                    wen_d   = 1'b1;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                addr_d  = addr_q + IRAM_ADDR_BITS'(1);
                wl_d    = (wl_q == 8'hFF) ? wl_q : wl_q + 8'd1;
                idx_d   = idx_q + 9'd1;
                state_d = ((idx_q + 9'd1) == n_words_c) ? CHECK : DATA_HI;
            end
            CHECK: begin
                if (take_c) begin
                    if (bus.r_data == csum_q) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        hold_d  = 1'b0;
                    end else begin
                        state_d = ERROR;
                        err_d   = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Inter-byte stall inside a frame aborts the load; the CPU stays held.
        if (timeout_c) begin
            state_d = ERROR;
            err_d   = 1'b1;
            tmo_d   = '0;
        end
    end

    assign bus.rd_uart  = rd_q;
    assign bus.iram_wa  = addr_q;
    assign bus.iram_wen = wen_q;
    assign bus.iram_din = din_q;
    assign cpu_hold     = hold_q;
    assign load_done    = done_q;
    assign load_error   = err_q;
    assign words_loaded = wl_q;
endmodule

// File: tb/tb_uart_iram_loader.sv
// Scoreboard bench: a queue-based FIFO model feeds frames, a monitor checks every IRAM write.
module tb_uart_iram_loader;
    typedef struct packed {
        logic [7:0]  addr;
        logic [15:0] data;
    } wr_t;

    logic       clk;
    logic       reset;
    logic       cpu_hold;
    logic       load_done;
    logic       load_error;
    logic [7:0] words_loaded;

    int checks = 0;
    int errors = 0;

    logic [7:0] fifo_q [$];
    wr_t        exp_q  [$];
    logic       prev_wen = 1'b0;

    uart_iram_loader_if #(.WIDTH(16), .IRAM_ADDR_BITS(8)) bus ();

    uart_iram_loader #(
        .WIDTH(16), .IRAM_ADDR_BITS(8), .SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(100)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus),
        .cpu_hold(cpu_hold), .load_done(load_done),
        .load_error(load_error), .words_loaded(words_loaded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic refresh();
        bus.rx_empty = (fifo_q.size() == 0);
        bus.r_data   = (fifo_q.size() == 0) ? 8'h00 : fifo_q[0];
    endtask

    task automatic push_byte(input logic [7:0] b);
        fifo_q.push_back(b);
        refresh();
    endtask

    task automatic exp_wr(input logic [7:0] a, input logic [15:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic chk_status(input string tag, input logic h, input logic d,
                              input logic e, input logic [7:0] w);
        chk({tag, "_cpu_hold"},     32'(cpu_hold),     32'(h));
        chk({tag, "_load_done"},    32'(load_done),    32'(d));
        chk({tag, "_load_error"},   32'(load_error),   32'(e));
        chk({tag, "_words_loaded"}, 32'(words_loaded), 32'(w));
    endtask

    task automatic wait_drain(input string tag, input int budget, input int settle);
        int n = 0;
        while (fifo_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (fifo_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s_drain fifo_left=%0d required=0", tag, fifo_q.size());
        end
        repeat (settle) @(negedge clk);
    endtask

    // FIFO model: pop on rd_uart, flag any pop of an empty FIFO.
    initial begin
        bus.rx_empty = 1'b1;
        bus.r_data   = 8'h00;
        forever begin
            @(posedge clk);
            if (bus.rd_uart) begin
                checks++;
                if (fifo_q.size() == 0) begin
                    errors++;
                    $display("FAIL pop_on_empty actual=1 required=0");
                end else begin
                    void'(fifo_q.pop_front());
                end
            end
            #1 refresh();
        end
    end

    // Write monitor: every iram_wen pulse must match the next expected write.
    always @(negedge clk) begin
        if (bus.iram_wen) begin
            wr_t e;
            checks++;
            if (prev_wen) begin
                errors++;
                $display("FAIL wen_pulse_width actual=2+ required=1");
            end else if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write addr=%0h data=%0h required=none",
                         bus.iram_wa, bus.iram_din);
            end else begin
                e = exp_q.pop_front();
                if (e.addr !== bus.iram_wa || e.data !== bus.iram_din) begin
                    errors++;
                    $display("FAIL write actual=%0h:%0h required=%0h:%0h",
                             bus.iram_wa, bus.iram_din, e.addr, e.data);
                end
            end
        end
        prev_wen = bus.iram_wen;
    end

    initial begin
        logic [7:0] f_good [7];
        logic [7:0] f_bad  [5];
        logic [7:0] f_tmo  [4];
        logic [7:0] f_post [5];
        int n;

        f_good = '{8'hA5, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hBE};
        f_bad  = '{8'hA5, 8'h01, 8'h00, 8'h01, 8'h00};
        f_tmo  = '{8'hA5, 8'h03, 8'h11, 8'h22};
        f_post = '{8'hA5, 8'h01, 8'hBE, 8'hEF, 8'hAD};

        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk_status("reset", 1'b0, 1'b0, 1'b0, 8'd0);
        chk("reset_rd_uart", 32'(bus.rd_uart), 32'd0);
        chk("reset_iram_wen", 32'(bus.iram_wen), 32'd0);
        chk("reset_iram_wa", 32'(bus.iram_wa), 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // Good two-word frame.
        exp_wr(8'h00, 16'h1234);
        exp_wr(8'h01, 16'hABCD);
        foreach (f_good[i]) push_byte(f_good[i]);
        wait_drain("good", 200, 4);
        chk_status("good", 1'b0, 1'b1, 1'b0, 8'd2);
        chk("good_writes_pending", 32'(exp_q.size()), 32'd0);

        // Checksum mismatch.
        exp_wr(8'h00, 16'h0001);
        foreach (f_bad[i]) push_byte(f_bad[i]);
        wait_drain("bad", 200, 4);
        chk_status("bad", 1'b1, 1'b0, 1'b1, 8'd1);
        chk("bad_writes_pending", 32'(exp_q.size()), 32'd0);

        // Garbage bytes are popped and discarded, then a good frame.
        push_byte(8'h00);
        push_byte(8'hFF);
        push_byte(8'h5A);
        wait_drain("garbage", 100, 4);
        chk_status("garbage", 1'b1, 1'b0, 1'b1, 8'd1);
        exp_wr(8'h00, 16'h1234);
        exp_wr(8'h01, 16'hABCD);
        foreach (f_good[i]) push_byte(f_good[i]);
        wait_drain("good2", 200, 4);
        chk_status("good2", 1'b0, 1'b1, 1'b0, 8'd2);
        chk("good2_writes_pending", 32'(exp_q.size()), 32'd0);

        // Stall mid-frame: error must land roughly TIMEOUT_CYCLES after the last pop.
        exp_wr(8'h00, 16'h1122);
        foreach (f_tmo[i]) push_byte(f_tmo[i]);
        wait_drain("tmo", 200, 0);
        repeat (95) @(negedge clk);
        chk("tmo_not_early", 32'(load_error), 32'd0);
        n = 0;
        while (!load_error && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("tmo_fired", 32'(load_error), 32'd1);
        chk_status("tmo", 1'b1, 1'b0, 1'b1, 8'd1);
        chk("tmo_writes_pending", 32'(exp_q.size()), 32'd0);

        // N=0 means 256 words; words_loaded saturates at 255.
        push_byte(8'hA5);
        push_byte(8'h00);
        for (int i = 0; i < 512; i++) push_byte(8'h01);
        push_byte(8'h00);
        for (int i = 0; i < 256; i++) exp_wr(8'(i), 16'h0101);
        wait_drain("n256", 3000, 4);
        chk_status("n256", 1'b0, 1'b1, 1'b0, 8'd255);
        chk("n256_writes_pending", 32'(exp_q.size()), 32'd0);

        // Asynchronous reset while in DATA_LO with the FIFO still holding a byte.
        push_byte(8'hA5);
        push_byte(8'h02);
        push_byte(8'h12);
        push_byte(8'h34);
        n = 0;
        while (fifo_q.size() != 1 && n < 100) begin
            @(posedge clk);
            #2;
            n++;
        end
        chk("mid_hold_before_reset", 32'(cpu_hold), 32'd1);
        reset = 1'b0;
        #1;
        chk_status("mid_reset", 1'b0, 1'b0, 1'b0, 8'd0);
        chk("mid_reset_iram_wa", 32'(bus.iram_wa), 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("mid_reset_no_pop", 32'(bus.rd_uart), 32'd0);
        end
        chk("mid_reset_fifo_kept", 32'(fifo_q.size()), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        exp_wr(8'h00, 16'hBEEF);
        foreach (f_post[i]) push_byte(f_post[i]);
        wait_drain("post", 200, 4);
        chk_status("post", 1'b0, 1'b1, 1'b0, 8'd1);
        chk("post_writes_pending", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
